piso_shift_register: RTL and testbench



---
 rtl/piso_shift_register.sv | 154 +++++++++++++++
 tb/tb_piso_shift_register.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_register.sv
// ---------------------------------------------------------------------------
// piso_shift_register
//   Parallel-in serial-out shift register. A WIDTH-bit word is captured
//   through a load/ready handshake and presented one bit at a time on
//   serial_out. Each bit advances on the shared shift strobe. A PISO and a
//   SIPO wired serial_out->serial_in with a common shift therefore move a
//   word end to end.
//
//   Parameters
//     WIDTH      word width in bits (>= 2)
//     MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//
//   Ports
//     clk         rising-edge clock
//     reset       asynchronous, active-high reset
//     load        capture request; accepted only while ready=1
//     data_in     parallel word to serialize
//     shift       advance strobe; downstream samples serial_out on it
//     ready       idle, a load will be accepted
//     busy        a word is being serialized
//     serial_out  registered bit currently presented
//     done        one-cycle pulse after the final bit is consumed
//     bit_cnt     index of the bit currently presented (0-based)
//
//   Build option
//     PISO_PARITY_EN  when defined, an even-parity bit (XOR of the captured
//                     word) is sent after the data bits, with bit_cnt=WIDTH.
//                     A word then takes WIDTH+1 strobes.
// ---------------------------------------------------------------------------
module piso_shift_register #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load,
    input  logic [WIDTH-1:0]               data_in,
    input  logic                           shift,
    output logic                           ready,
    output logic                           busy,
    output logic                           serial_out,
    output logic                           done,
    output logic [$clog2(WIDTH+1)-1:0]     bit_cnt
);

    localparam int CW = $clog2(WIDTH+1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg,  sreg_nxt;
    logic [CW-1:0]    cnt,   cnt_nxt;
    logic             sout,  sout_nxt;
    logic             done_r, done_nxt;
`ifdef PISO_PARITY_EN
    logic             par,   par_nxt;
`endif

    // Register stage: every output comes straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            sreg   <= '0;
            cnt    <= '0;
            sout   <= 1'b0;
            done_r <= 1'b0;
`ifdef PISO_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            sreg   <= sreg_nxt;
            cnt    <= cnt_nxt;
            sout   <= sout_nxt;
            done_r <= done_nxt;
`ifdef PISO_PARITY_EN
            par    <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        sout_nxt  = sout;
        done_nxt  = 1'b0;
`ifdef PISO_PARITY_EN
        par_nxt   = par;
`endif
        case (state)
            IDLE: begin
                // shift is ignored here, including on the accepting edge.
                if (load) begin
                    sreg_nxt  = data_in;
                    cnt_nxt   = '0;
                    sout_nxt  = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
                    state_nxt = SHIFT;
`ifdef PISO_PARITY_EN
                    par_nxt   = ^data_in;
`endif
                end
            end
            SHIFT: begin
                if (shift) begin
                    if (cnt == LAST) begin
`ifdef PISO_PARITY_EN
                        state_nxt = PARITY;
                        cnt_nxt   = CW'(WIDTH);
                        sout_nxt  = par;
`else
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        sout_nxt  = 1'b0;
                        sreg_nxt  = '0;
                        done_nxt  = 1'b1;
`endif
                    end else begin
                        // The bit after the one on serial_out sits next to
                        // the exit end of the register.
                        sreg_nxt = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                                             : {1'b0, sreg[WIDTH-1:1]};
                        sout_nxt = MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
                        cnt_nxt  = cnt + 1'b1;
                    end
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                if (shift) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    sout_nxt  = 1'b0;
                    sreg_nxt  = '0;
                    done_nxt  = 1'b1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign ready      = (state == IDLE);
    assign busy       = (state != IDLE);
    assign serial_out = sout;
    assign done       = done_r;
    assign bit_cnt    = cnt;

endmodule

// File: tb/tb_piso_shift_register.sv
module tb_piso_shift_register;

`ifdef PISO_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0, shift = 1'b0;
    logic [7:0] data_in = '0;
    logic       ready, busy, serial_out, done;
    logic [3:0] bit_cnt;

    logic       l_load = 1'b0, l_shift = 1'b0;
    logic [7:0] l_data = '0;
    logic       l_ready, l_busy, l_sout, l_done;
    logic [3:0] l_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    piso_shift_register #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .reset(reset), .load(load), .data_in(data_in), .shift(shift),
        .ready(ready), .busy(busy), .serial_out(serial_out), .done(done),
        .bit_cnt(bit_cnt)
    );

    piso_shift_register #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .load(l_load), .data_in(l_data), .shift(l_shift),
        .ready(l_ready), .busy(l_busy), .serial_out(l_sout), .done(l_done),
        .bit_cnt(l_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // seq holds the expected wire order: seq[8] first, seq[0] is the parity slot.
    task automatic run_word(input string tag, input logic [7:0] d,
                            input logic [8:0] seq, input logic sh_on_load);
        load = 1'b1; data_in = d; shift = sh_on_load;
        tick;
        load = 1'b0; shift = 1'b0;
        for (int i = 0; i < NB; i++) begin
            chk({tag, "_bit"}, serial_out, seq[8-i]);
            chk({tag, "_cnt"}, bit_cnt, i);
            chk({tag, "_busy"}, {busy, ready}, 2'b10);
            chk({tag, "_nodone"}, done, 0);
            shift = 1'b1;
            tick;
        end
        shift = 1'b0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_end"}, {ready, busy, serial_out, bit_cnt}, {3'b100, 4'd0});
        tick;
        chk({tag, "_pulse"}, done, 0);
    endtask

    initial begin
        logic [5:0] pat;
        logic [8:0] seq;
        logic [7:0] sipo;
        int k;
        int c;

        // Reset state
        #2;
        chk("rst_out", {ready, busy, serial_out, done, bit_cnt}, {4'b1000, 4'd0});
        tick;
        reset = 1'b0;
        tick;

        // shift in IDLE does nothing
        shift = 1'b1;
        tick;
        shift = 1'b0;
        chk("idle_shift", {ready, busy, serial_out, bit_cnt}, {3'b100, 4'd0});

        // Test 1: A5 MSB first, shift also high on the load edge
        run_word("a5", 8'hA5, {8'b10100101, 1'b0}, 1'b1);

        // Test 2: C3 with strobe gaps (pattern 1,0,0,1,1,0 repeating)
        pat = 6'b100110;
        seq = {8'b11000011, 1'b0};
        load = 1'b1; data_in = 8'hC3;
        tick;
        load = 1'b0;
        k = 0;
        c = 0;
        while (k < NB && c < 60) begin
            chk("c3_bit", serial_out, seq[8-k]);
            chk("c3_cnt", bit_cnt, k);
            chk("c3_nodone", done, 0);
            shift = pat[5 - (c % 6)];
            tick;
            if (pat[5 - (c % 6)]) k++;
            c++;
        end
        shift = 1'b0;
        chk("c3_strobes", k, NB);
        chk("c3_done", {done, ready}, 2'b11);
        tick;

        // Test 3: load ignored while busy and on the completing edge
        seq = {8'b11110000, 1'b0};
        load = 1'b1; data_in = 8'hF0;
        tick;
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            shift = 1'b1;
            tick;
        end
        load = 1'b1; data_in = 8'h0F;
        for (int i = 3; i < NB; i++) begin
            chk("f0_bit", serial_out, seq[8-i]);
            chk("f0_cnt", bit_cnt, i);
            shift = 1'b1;
            tick;
        end
        shift = 1'b0;
        chk("f0_done", {done, ready, busy}, 3'b110);
        tick;
        load = 1'b0;
        chk("0f_capt", {busy, ready, serial_out, bit_cnt}, {3'b100, 4'd0});
        seq = {8'b00001111, 1'b0};
        for (int i = 0; i < NB; i++) begin
            chk("0f_bit", serial_out, seq[8-i]);
            shift = 1'b1;
            tick;
        end
        shift = 1'b0;
        chk("0f_done", done, 1);
        tick;

        // Test 4: asynchronous reset mid-word
        load = 1'b1; data_in = 8'hFF;
        tick;
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            shift = 1'b1;
            tick;
        end
        shift = 1'b0;
        chk("ff_mid", {busy, serial_out, bit_cnt}, {2'b11, 4'd4});
        #2 reset = 1'b1;
        #1;
        chk("arst", {ready, busy, serial_out, done, bit_cnt}, {4'b1000, 4'd0});
        #2 reset = 1'b0;
        tick;
        run_word("81", 8'h81, {8'b10000001, 1'b0}, 1'b0);

        // Test 5: LSB first, looped into a bench SIPO sharing the strobe
        l_load = 1'b1; l_data = 8'h01;
        tick;
        l_load = 1'b0;
        sipo = '0;
        seq = {8'b10000000, 1'b1};
        for (int i = 0; i < NB; i++) begin
            chk("lsb_bit", l_sout, seq[8-i]);
            chk("lsb_cnt", l_cnt, i);
            if (i < 8) sipo = {l_sout, sipo[7:1]};
            l_shift = 1'b1;
            tick;
        end
        l_shift = 1'b0;
        chk("lsb_done", {l_done, l_ready}, 2'b11);
        chk("sipo", sipo, 8'h01);
        tick;

`ifdef PISO_PARITY_EN
        // Test 6: parity bit follows the data
        run_word("p07", 8'h07, {8'b00000111, 1'b1}, 1'b0);
        run_word("p03", 8'h03, {8'b00000011, 1'b0}, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
